mux_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the shared 4-input, 4-bit word multiplexer. Four requesters each present a 4-bit word and a request. The block grants one requester at a time and drives the 2-bit mux select. It forwards the selected word to a single consumer over a valid/ready handshake, with a bounded burst length per grant so no requester starves.

---
 rtl/mux_arbiter_if.sv | 25 ++
 rtl/mux_arbiter.sv | 97 +++++++++
 tb/tb_mux_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mux_arbiter_if.sv
// Bus between the four requesters, the consumer and the round-robin mux arbiter.
// The arbiter uses the slave modport; the requester/consumer side uses master.
interface mux_arbiter_if;
  logic [3:0] req;
  logic [3:0] w0;
  logic [3:0] w1;
  logic [3:0] w2;
  logic [3:0] w3;
  logic       y_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic [3:0] y;
  logic       y_valid;
  logic       busy;

  modport master (
    output req, w0, w1, w2, w3, y_ready,
    input  sel, gnt, y, y_valid, busy
  );

  modport slave (
    input  req, w0, w1, w2, w3, y_ready,
    output sel, gnt, y, y_valid, busy
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin arbiter for a 4-input word mux: grants one requester at a time,
// forwards its word over valid/ready, and releases after BURST beats or a request drop.
module mux_arbiter #(
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_arbiter_if.slave  bus
);
  localparam int DATA_W = 4;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ptr, ptr_nxt;
  logic [1:0]  sel, sel_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  gnt, gnt_nxt;
  logic [1:0]  pick;
  logic        busy;
  logic        xfer;
  logic        last;
  logic [DATA_W-1:0] y;

  // Scan from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    pick = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[2'(ptr + 2'(i))]) pick = 2'(ptr + 2'(i));
    end
  end

  assign busy = (state == GRANT);
  assign xfer = bus.y_valid & bus.y_ready;
  assign last = (cnt == 4'(BURST - 1));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    cnt_nxt   = cnt;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (|bus.req) begin
          state_nxt = GRANT;
          sel_nxt   = pick;
          gnt_nxt   = 4'b0001 << pick;
          cnt_nxt   = 4'd0;
        end
      end
      GRANT: begin
        // Drop and burst end share one release path, so ptr advances once.
        if (!bus.req[sel] || (xfer && last)) begin
          state_nxt = IDLE;
          ptr_nxt   = sel + 2'd1;
          gnt_nxt   = 4'd0;
          cnt_nxt   = 4'd0;
        end else if (xfer) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      sel   <= 2'd0;
      cnt   <= 4'd0;
      gnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
      gnt   <= gnt_nxt;
    end
  end

  always_comb begin
    case (sel)
      2'd0:    y = bus.w0;
      2'd1:    y = bus.w1;
      2'd2:    y = bus.w2;
      default: y = bus.w3;
    endcase
  end

  assign bus.sel     = sel;
  assign bus.gnt     = gnt;
  assign bus.busy    = busy;
  assign bus.y_valid = busy & bus.req[sel];
  assign bus.y       = y;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter: stimulus queues expected {sel, word} beats,
// a negedge monitor pops and compares every accepted transfer.
module tb_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  mux_arbiter_if bus();

  mux_arbiter #(.BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  logic [3:0] wv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int r, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({2'(r), wv[r]});
  endtask

  // Monitor: invariant plus scoreboard compare on every accepted beat.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("gnt_onehot", {28'd0, bus.gnt}, bus.busy ? (32'd1 << bus.sel) : 32'd0);
      if (bus.y_valid && bus.y_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got sel=%0d y=%0h, expected no transfer at %0t",
                   bus.sel, bus.y, $time);
        end else begin
          logic [5:0] e;
          e = exp_q.pop_front();
          check("xfer", {26'd0, bus.sel, bus.y}, {26'd0, e});
        end
      end
    end
  end

  initial begin
    wv[0] = 4'h1; wv[1] = 4'h5; wv[2] = 4'hA; wv[3] = 4'hC;
    bus.w0 = wv[0]; bus.w1 = wv[1]; bus.w2 = wv[2]; bus.w3 = wv[3];
    bus.req = 4'b0000;
    bus.y_ready = 1'b0;

    // Reset state
    tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.y_valid, 0);
    check("rst_sel", bus.sel, 0);
    check("rst_y", bus.y, 4'h1);
    tick();
    rst = 1'b0;

    // Single burst from requester 2, then regrant after one bubble
    bus.req = 4'b0100;
    bus.y_ready = 1'b1;
    push(2, 4);
    tick();
    check("sb_gnt", bus.gnt, 4'b0100);
    check("sb_sel", bus.sel, 2);
    check("sb_busy", bus.busy, 1);
    repeat (3) begin
      tick();
      check("sb_busy_mid", bus.busy, 1);
    end
    tick();
    check("sb_release_busy", bus.busy, 0);
    check("sb_release_gnt", bus.gnt, 0);
    tick();
    check("sb_regrant", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    tick();
    check("sb_drop_idle", bus.busy, 0);

    // Early drop: ptr is 3, requester 3 granted, drops after one beat
    bus.req = 4'b1000;
    push(3, 1);
    tick();
    check("ed_sel", bus.sel, 3);
    tick();
    bus.req = 4'b0011;
    tick();
    check("ed_release", bus.busy, 0);
    tick();
    check("ed_next_sel", bus.sel, 0);
    check("ed_next_gnt", bus.gnt, 4'b0001);
    bus.req = 4'b0010;
    tick();
    check("ed2_release", bus.busy, 0);

    // Back-pressure on requester 1 mid-burst
    push(1, 4);
    tick();
    check("bp_gnt", bus.gnt, 4'b0010);
    tick();
    bus.y_ready = 1'b0;
    repeat (3) begin
      tick();
      check("bp_hold_gnt", bus.gnt, 4'b0010);
      check("bp_hold_valid", bus.y_valid, 1);
    end
    bus.y_ready = 1'b1;
    repeat (2) begin
      tick();
      check("bp_busy", bus.busy, 1);
    end
    tick();
    check("bp_release", bus.busy, 0);

    // Simultaneous requests with ptr=2: requester 3 wins, then ptr wraps to 0
    bus.req = 4'b1011;
    push(3, 4);
    tick();
    check("sim_sel", bus.sel, 3);
    check("sim_gnt", bus.gnt, 4'b1000);
    repeat (3) tick();
    tick();
    check("sim_release", bus.busy, 0);
    tick();
    check("sim_wrap_sel", bus.sel, 0);
    bus.req = 4'b0000;
    tick();
    check("sim_idle", bus.busy, 0);

    // Reset mid-burst: ptr is 1, requester 1 gets one beat in before reset
    bus.req = 4'b1111;
    push(1, 1);
    tick();
    check("mr_sel", bus.sel, 1);
    tick();
    rst = 1'b1;
    #1;
    check("mr_gnt", bus.gnt, 0);
    check("mr_busy", bus.busy, 0);
    check("mr_valid", bus.y_valid, 0);
    check("mr_sel0", bus.sel, 0);
    check("mr_y", bus.y, 4'h1);
    tick();
    rst = 1'b0;

    // Round-robin fairness with all four requesting
    for (int g = 0; g < 5; g++) begin
      int r;
      r = g % 4;
      push(r, 4);
      tick();
      check("rr_sel", bus.sel, r);
      check("rr_gnt", bus.gnt, 32'd1 << r);
      repeat (3) tick();
      tick();
      check("rr_bubble", bus.busy, 0);
    end
    bus.req = 4'b0000;
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
